cnt60_run_ctrl: RTL

- Run controller for the mod-60 up/down counter: drives its ENABLE, DEC and a counter-clear strobe from user buttons and a prescaled timebase.
- Provides start/pause/resume, direction select, clear, and countdown-to-zero alarm.
- Sits between the board button inputs and one mod-60 counter instance; the counter's CNT10/CNT6 outputs feed back into this block.

---
 rtl/cnt60_run_ctrl.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/cnt60_run_ctrl.sv
// rtl/cnt60_run_ctrl.sv - run controller for the mod-60 up/down counter
//
// Turns the start/pause and clear buttons plus a prescaled timebase into the
// ENABLE tick, DEC direction and CNT_CLR_N clear strobe of one mod-60 counter,
// and raises ALARM for ALARM_TICKS tick periods when a countdown reaches 00.
//
// Ports:
//   CLK        clock
//   RESET      asynchronous active-low reset
//   START_BTN  start/pause/resume button (asynchronous level, active-high)
//   CLR_BTN    clear button (asynchronous level, active-high)
//   MODE_DOWN  1 = count down, 0 = count up; sampled only when leaving IDLE
//   CNT10      counter ones digit (0..9), fed back from the counter
//   CNT6       counter tens digit (0..5), fed back from the counter
//   ENABLE     one-cycle count tick to the counter
//   DEC        counter direction (1 = increment, 0 = decrement)
//   CNT_CLR_N  one-cycle active-low clear strobe to the counter
//   ALARM      countdown-expired indicator
//   STATE      FSM state: IDLE=0, RUN=1, PAUSE=2, ALARM=3

module cnt60_run_ctrl #(
  parameter int PRESCALE    = 50000000,
  parameter int ALARM_TICKS = 5
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       START_BTN,
  input  logic       CLR_BTN,
  input  logic       MODE_DOWN,
  input  logic [3:0] CNT10,
  input  logic [2:0] CNT6,
  output logic       ENABLE,
  output logic       DEC,
  output logic       CNT_CLR_N,
  output logic       ALARM,
  output logic [1:0] STATE
);

  localparam int PSC_W = (PRESCALE > 2) ? $clog2(PRESCALE) : 1;
  localparam int AT_W  = $clog2(ALARM_TICKS + 1);
  localparam logic [PSC_W-1:0] PSC_LAST   = PSC_W'(PRESCALE - 1);
  localparam logic [AT_W-1:0]  ATICK_LAST = AT_W'(ALARM_TICKS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_ALRM  = 2'd3
  } state_t;

  state_t            state, state_d;
  logic [PSC_W-1:0]  psc, psc_d;
  logic [AT_W-1:0]   atick, atick_d;
  logic              dec_d, enable_d, clr_n_d, alarm_d;
  logic [2:0]        start_sync, clr_sync;
  logic              start_ev, clr_ev, psc_wrap, cnt_zero, terminal;

  // Two synchronizer flops plus one history flop per button; the event is
  // the synchronized level rising against the history flop.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      start_sync <= 3'b000;
      clr_sync   <= 3'b000;
    end else begin
      start_sync <= {start_sync[1:0], START_BTN};
      clr_sync   <= {clr_sync[1:0], CLR_BTN};
    end
  end

  assign start_ev = start_sync[1] & ~start_sync[2];
  assign clr_ev   = clr_sync[1] & ~clr_sync[2];
  assign psc_wrap = (psc == PSC_LAST);
  assign cnt_zero = (CNT10 == 4'd0) && (CNT6 == 3'd0);
  // ENABLE low here means the 00 on the counter is already the result of the
  // last tick, so the countdown is complete.
  assign terminal = (state == ST_RUN) && !DEC && cnt_zero && !ENABLE;

  // State register
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) state <= ST_IDLE;
    else        state <= state_d;
  end

  // Next-state logic; clear overrides everything, terminal overrides start.
  always_comb begin
    state_d = state;
    if (clr_ev) begin
      state_d = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  if (start_ev && !(MODE_DOWN && cnt_zero)) state_d = ST_RUN;
        ST_RUN:   if (terminal) state_d = ST_ALRM;
                  else if (start_ev) state_d = ST_PAUSE;
        ST_PAUSE: if (start_ev) state_d = ST_RUN;
        ST_ALRM:  if (start_ev || (psc_wrap && atick == ATICK_LAST)) state_d = ST_IDLE;
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values. The prescaler advances only while the
  // FSM stays in RUN or ALARM, so a pause freezes it mid-period.
  always_comb begin
    psc_d    = psc;
    atick_d  = atick;
    dec_d    = DEC;
    enable_d = 1'b0;
    clr_n_d  = 1'b1;
    alarm_d  = (state_d == ST_ALRM);
    if (clr_ev) begin
      clr_n_d = 1'b0;
      psc_d   = '0;
      atick_d = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (state_d == ST_RUN) begin
            dec_d = ~MODE_DOWN;
            psc_d = '0;
          end
        end
        ST_RUN: begin
          if (state_d == ST_ALRM) begin
            psc_d   = '0;
            atick_d = '0;
          end else if (state_d == ST_RUN) begin
            psc_d    = psc_wrap ? '0 : psc + 1'b1;
            enable_d = psc_wrap;
          end
        end
        ST_ALRM: begin
          if (state_d == ST_ALRM) begin
            psc_d = psc_wrap ? '0 : psc + 1'b1;
            if (psc_wrap) atick_d = atick + 1'b1;
          end else begin
            psc_d   = '0;
            atick_d = '0;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      psc       <= '0;
      atick     <= '0;
      DEC       <= 1'b1;
      ENABLE    <= 1'b0;
      CNT_CLR_N <= 1'b1;
      ALARM     <= 1'b0;
    end else begin
      psc       <= psc_d;
      atick     <= atick_d;
      DEC       <= dec_d;
      ENABLE    <= enable_d;
      CNT_CLR_N <= clr_n_d;
      ALARM     <= alarm_d;
    end
  end

  assign STATE = state;

endmodule
